// File: rtl/kyber_pkg.sv
// Shared Kyber constants, legal compression widths and the decompressor state encoding.
package kyber_pkg;

   localparam int KYBER_Q = 3329;
   localparam int KYBER_N = 256;

   localparam logic [3:0] D_1  = 4'd1;
   localparam logic [3:0] D_4  = 4'd4;
   localparam logic [3:0] D_5  = 4'd5;
   localparam logic [3:0] D_10 = 4'd10;
   localparam logic [3:0] D_11 = 4'd11;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UNPACK, S_DRAIN} state_e;

   function automatic logic d_legal(input logic [3:0] d);
      return (d == D_1) || (d == D_4) || (d == D_5) || (d == D_10) || (d == D_11);
   endfunction

   function automatic int bytes_for_d(input logic [3:0] d);
      return KYBER_N * int'(d) / 8;
   endfunction

endpackage

// File: rtl/decompress_d_cal.sv
// One decompression lane: y = round(x * Q / 2^d), registered under a load enable.
module decompress_d_cal import kyber_pkg::*; #(
   parameter int CW = 16,
   parameter int Q  = KYBER_Q
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [3:0]    d,
   input  logic [10:0]   x,
   output logic [CW-1:0] y
);
   // The 23-bit product covers x < 2^11; adding half an output LSB rounds half-up.
   function automatic logic [11:0] round_mul(input logic [10:0] xv, input logic [3:0] dv);
      logic [22:0] prod;
      prod = 23'(xv) * 23'(Q) + (23'd1 << (dv - 4'd1));
      return 12'(prod >> dv);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   y <= '0;
      else if (en) y <= CW'(round_mul(x, d));
   end
endmodule

// File: rtl/dual_ram.sv
// Simple dual-port RAM: port 2 writes, port 1 reads with one cycle of latency.
module dual_ram #(
   parameter int DW = 8,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          en,
   input  logic [AW-1:0] addr1,
   output logic [DW-1:0] dout1,
   input  logic          we2,
   input  logic [AW-1:0] addr2,
   input  logic [DW-1:0] din2
);
   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we2) mem_q[addr2] <= din2;
         dout1 <= mem_q[addr1];
      end
   end
endmodule

// File: rtl/decompress_d.sv
// Kyber decompressor: buffers one packed polynomial of d-bit fields, then streams
// LANES rounded coefficients per beat over a valid/ready interface.
module decompress_d import kyber_pkg::*; #(
   parameter int Q     = KYBER_Q,
   parameter int N     = KYBER_N,
   parameter int LANES = 2,
   parameter int CW    = 16,
   parameter int AW    = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                set,
   input  logic                start,
   input  logic [3:0]          d_sel,
   output logic                in_ready,
   input  logic                din_valid,
   input  logic [7:0]          din,
   input  logic [AW-1:0]       din_index,
   input  logic                din_last,
   output logic                dout_valid,
   input  logic                dout_ready,
   output logic [LANES*CW-1:0] dout_coef,
   output logic [7:0]          dout_index,
   output logic                dout_last,
   output logic                busy,
   output logic                err
);
   // Extra byte of headroom beyond LANES*11+8 lets reads stream every cycle at d=11.
   localparam int ACC_W = LANES*11 + 16;
   localparam int CNT_W = $clog2(ACC_W + 1);
   localparam int BEATS = N / LANES;
   localparam int PW    = $clog2(BEATS + 1);

   state_e              state_q, state_d;
   logic [3:0]          d_q;
   logic                err_q;
   logic [ACC_W-1:0]    acc_q, acc_d, acc_post;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_post, lw;
   logic [AW:0]         rd_addr_q, nbytes;
   logic                rd_pend_q;
   logic [7:0]          rd_byte;
   logic [PW-1:0]       pops_q;
   logic                vld_p1_q, vld_p2_q;
   logic [LANES*CW-1:0] coef_q, coef_p1;
   logic [7:0]          idx_q;
   logic [10:0]         dmask;
   logic [10:0]         x_p0 [LANES];
   logic [CW-1:0]       y_p1 [LANES];
   logic                adv_p1, adv_p2, pop, issue;

   dual_ram #(.DW(8), .AW(AW)) u_ram (
      .clk   (clk),
      .en    (set),
      .addr1 (rd_addr_q[AW-1:0]),
      .dout1 (rd_byte),
      .we2   (din_valid & in_ready),
      .addr2 (din_index),
      .din2  (din)
   );

   always_comb begin
      lw       = CNT_W'(LANES * int'(d_q));
      nbytes   = (AW+1)'(bytes_for_d(d_q));
      adv_p2   = !vld_p2_q || dout_ready;
      adv_p1   = !vld_p1_q || adv_p2;
      pop      = (state_q == S_UNPACK) && adv_p1 && (cnt_q >= lw) && (pops_q < PW'(BEATS));
      cnt_post = pop ? cnt_q - lw : cnt_q;
      acc_post = pop ? acc_q >> lw : acc_q;
      issue    = (state_q == S_UNPACK) && (rd_addr_q < nbytes) &&
                 ((int'(cnt_post) + (rd_pend_q ? 16 : 8)) <= ACC_W);
      acc_d    = acc_post;
      cnt_d    = cnt_post;
      if (rd_pend_q) begin
         acc_d = acc_post | (ACC_W'(rd_byte) << cnt_post);
         cnt_d = cnt_post + CNT_W'(8);
      end
      dmask   = 11'((12'd1 << d_q) - 12'd1);
      coef_p1 = '0;
      for (int k = 0; k < LANES; k++) begin
         x_p0[k] = 11'(acc_q >> (k * int'(d_q))) & dmask;
         coef_p1[k*CW +: CW] = y_p1[k];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start && d_legal(d_sel)) state_d = S_LOAD;
         S_LOAD:   if (din_valid && din_last) state_d = S_UNPACK;
         S_UNPACK: if (pop && pops_q == PW'(BEATS - 1)) state_d = S_DRAIN;
         S_DRAIN:  if (vld_p2_q && dout_ready && dout_last) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // p0 -> p1: popped fields are rounded in the lane calculators
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      decompress_d_cal #(.CW(CW), .Q(Q)) u_cal (
         .clk   (clk),
         .reset (reset),
         .en    (set & pop),
         .d     (d_q),
         .x     (x_p0[k]),
         .y     (y_p1[k])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         d_q       <= '0;
         err_q     <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         rd_addr_q <= '0;
         rd_pend_q <= 1'b0;
         pops_q    <= '0;
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         coef_q    <= '0;
         idx_q     <= '0;
      end else if (set) begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= issue;
         if (issue)  rd_addr_q <= rd_addr_q + (AW+1)'(1);
         if (pop)    pops_q    <= pops_q + PW'(1);
         if (adv_p1) vld_p1_q  <= pop;
         // p1 -> p2: output register, frozen while the consumer stalls
         if (adv_p2) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) coef_q <= coef_p1;
         end
         if (vld_p2_q && dout_ready) idx_q <= idx_q + 8'(LANES);
         if (state_q == S_IDLE && start) begin
            err_q <= !d_legal(d_sel);
            if (d_legal(d_sel)) begin
               d_q       <= d_sel;
               acc_q     <= '0;
               cnt_q     <= '0;
               rd_addr_q <= '0;
               pops_q    <= '0;
               idx_q     <= '0;
            end
         end
      end
   end

   assign in_ready   = (state_q == S_LOAD);
   assign dout_valid = vld_p2_q;
   assign dout_coef  = coef_q;
   assign dout_index = idx_q;
   assign dout_last  = vld_p2_q && (idx_q == 8'(N - LANES));
   assign busy       = (state_q != S_IDLE);
   assign err        = err_q;

endmodule
